// File: rtl/mnist_frame_sender_if.sv
// Pixel-memory read port and uart_tx byte port of the frame sender.
// The sender drives the master side; memory and transmitter sit on the slave side.
interface mnist_frame_sender_if;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_data;
  logic       tx_flag;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output tx_data,
    output tx_flag
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  tx_data,
    input  tx_flag
  );
endinterface

// File: rtl/mnist_frame_sender.sv
// MNIST frame sender: streams a PIXELS-byte image from a synchronous pixel
// memory into a uart_tx, one byte per BYTE_CYCLES+3 clocks so the
// transmitter (which has no busy output) is never overrun.
module mnist_frame_sender #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200,
  parameter int GAP_BITS = 11,
  parameter int PIXELS   = 784
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        start,
  input  logic                        abort,
  mnist_frame_sender_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic [9:0]                  byte_cnt
);

  localparam int BAUD_CNT    = CLK_FREQ / UART_BPS;
  localparam int BYTE_CYCLES = BAUD_CNT * GAP_BITS;
  localparam int GAP_W       = $clog2(BYTE_CYCLES + 1);

  localparam logic [9:0] LAST_ADDR = 10'(PIXELS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state;
  logic [9:0]       addr;
  logic [GAP_W-1:0] gap;
  logic [7:0]       tx_data_q;

  // Frame sequencer: fetch, load, strobe, then hold off for one byte time.
  // NOTE: every register here uses <= so all updates see the pre-edge values
  // of each other; mixing in = would make the result depend on statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      gap       <= '0;
      tx_data_q <= '0;
      byte_cnt  <= '0;
    end else if (abort && state != S_IDLE) begin
      // A strobe already issued is not recalled; counters keep their values.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          // abort arriving with start in IDLE suppresses the frame
          if (start && !abort) begin
            state    <= S_FETCH;
            addr     <= '0;
            byte_cnt <= '0;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          tx_data_q <= bus.rd_data;
          state     <= S_SEND;
        end
        S_SEND: begin
          byte_cnt <= byte_cnt + 10'd1;
          gap      <= GAP_W'(BYTE_CYCLES - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (gap == '0) begin
            if (addr == LAST_ADDR) begin
              state <= S_DONE;
            end else begin
              addr  <= addr + 10'd1;
              state <= S_FETCH;
            end
          end else begin
            gap <= gap - GAP_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes and status decode straight from the registered state, so they are
  // single-cycle and glitch-free; address and data are held registers.
  assign bus.rd_en   = (state == S_FETCH);
  assign bus.rd_addr = addr;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_flag = (state == S_SEND);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

endmodule

// File: doc/mnist_frame_sender.md
Name: mnist_frame_sender

Overview:
- UART-side image source for the MNIST pipeline, acting as the PC end of the pixel byte stream.
- Reads a PIXELS-byte image from a synchronous pixel memory and emits it byte-by-byte into a uart_tx instance via its pi_data/pi_flag pair.
- Paces bytes so the transmitter, which has no busy output, is never overrun.
- Used for on-board loopback and self-test of the receive → accelerator → result path without a PC.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate of the downstream uart_tx.
- GAP_BITS, 11, bit-times reserved per byte: 10 frame bits plus 1 guard bit.
- PIXELS, 784, number of bytes per frame; range 1..1024.
- Derived, not overridable: BAUD_CNT = CLK_FREQ/UART_BPS (integer division); BYTE_CYCLES = BAUD_CNT*GAP_BITS.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- abort  in  1  one-cycle pulse; cancels the frame in progress.
- rd_en  out  1  pixel memory read enable.
- rd_addr  out  10  pixel memory address.
- rd_data  in  8  pixel memory data; valid exactly one cycle after rd_en.
- tx_data  out  8  byte to uart_tx pi_data.
- tx_flag  out  1  one-cycle strobe to uart_tx pi_flag.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when the last byte's gap has elapsed.
- byte_cnt  out  10  number of bytes strobed in the current or last frame.

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - all outputs 0; state IDLE; gap counter 0.
  - Reset mid-frame aborts immediately; no done pulse.
- States:
  - IDLE: busy=0. start=1 → FETCH, address=0, byte_cnt=0.
  - FETCH (1 cycle): rd_en=1, rd_addr=current address → LOAD.
  - LOAD (1 cycle): tx_data<=rd_data → SEND.
  - SEND (1 cycle): tx_flag=1; byte_cnt increments; gap counter loaded with BYTE_CYCLES-1 → WAIT.
  - WAIT: counter decrements each cycle. At 0: if address==PIXELS-1 → DONE, else address+1 → FETCH.
  - DONE (1 cycle): done=1, busy=1 → IDLE.
- Timing:
  - With start sampled at edge k, rd_en is high in cycle k+1 and the first tx_flag is in cycle k+3.
  - Byte period is BYTE_CYCLES+3 cycles.
  - Frame length from start to done is PIXELS*(BYTE_CYCLES+3)+1 cycles.
- Output qualifiers:
  - busy=1 in FETCH, LOAD, SEND, WAIT and DONE.
  - tx_data stays stable from LOAD until the next LOAD. It is not cleared at frame end.
  - rd_addr holds its value when rd_en=0.
  - byte_cnt holds its final value after done until the next accepted start.
- start handling:
  - start is ignored in every state except IDLE, including the DONE cycle.
  - No queuing.
- abort handling:
  - abort in any non-IDLE state → IDLE next cycle; busy=0; no done.
  - A tx_flag already issued is not recalled.
  - abort in IDLE has no effect.
  - abort and start in the same cycle in IDLE: abort wins and the frame does not start.
- Boundary cases:
  - PIXELS=1 sends one byte, then DONE.
  - Address never exceeds PIXELS-1; there is no wrap-around.
  - tx_flag never asserts in consecutive cycles.

Test Plan:
- Reset and idle: CLK_FREQ=1000, UART_BPS=100, PIXELS=4, so BYTE_CYCLES=110. After reset, all outputs are 0. Hold idle 50 cycles → no rd_en, no tx_flag.
- Nominal frame: memory holds 0x11,0x22,0x33,0x44; start at cycle 0.
  - tx_flag at cycles 3, 116, 229, 342 with tx_data 0x11..0x44 respectively.
  - done at cycle 453; byte_cnt=4; busy falls the cycle after done.
- Pacing check: run the full frame at defaults (CLK_FREQ=50e6, UART_BPS=115200, PIXELS=784) into uart_tx looped back to uart_rx. All 784 bytes are received intact. The gap between tx_flag pulses is exactly 4777 cycles.
- Start while busy: pulse start again at cycle 50 and in the DONE cycle → no restart; timing is identical to the nominal frame.
- Abort mid-frame: abort at cycle 150 → busy=0 at 151, no done, byte_cnt=2. A new start at 200 sends from address 0 again.
- Reset mid-frame, plus abort+start together: sys_rst at cycle 120 → outputs 0 on the next cycle and no further tx_flag. In IDLE, start and abort in the same cycle → the frame does not start.
